spi_slave_bus: RTL and testbench

SPI responder (mode 0, MSB first) that lets an external SPI master, such as the MCU or a second board, reach the FPGA register space. It is the slave-side counterpart of the ADC SPI master. Incoming frames are decoded into single-cycle register read requests and write strobes on the same 12-bit address / 16-bit data map that the parallel bus uses. The block sits beside the bus decoder in core and shares its read mux and write targets.

---
 rtl/spi_slave_pkg.sv | 15 +
 rtl/spi_slave_bus_sync_edge.sv | 31 +++
 rtl/spi_slave_bus.sv | 138 +++++++++++++
 tb/tb_spi_slave_bus.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI register-access responder.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } state_t;

  localparam int CMD_WR_BIT = 15;
  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = $clog2(FRAME_BITS);

endpackage

// File: rtl/spi_slave_bus_sync_edge.sv
// N-stage input synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_bus.sv
// SPI mode-0 responder that turns framed commands into register read requests and write strobes.
//  state | meaning
//  IDLE  | CS high, nothing in flight
//  CMD   | shifting in the 16-bit command word
//  RD    | streaming read data out on SOMI, prefetching the next word
//  WR    | shifting in data words, one write strobe per word
module spi_slave_bus
  import spi_slave_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          SCLK,
  input  logic          CS,
  input  logic          SIMO,
  output logic          SOMI,
  output logic          SOMI_OE,
  output logic [AW-1:0] rd_addr,
  output logic          rd_req,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_en,
  output logic          busy
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic simo_s, simo_rise, simo_fall;
  logic unused_edges;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(SCLK),
    .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(CS),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_simo (
    .clk(clk), .rst_n(rst_n), .din(SIMO),
    .level(simo_s), .rise(simo_rise), .fall(simo_fall)
  );

  assign unused_edges = ^{sclk_s, cs_rise, cs_fall, simo_rise, simo_fall};

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [DW-1:0]    rx_shift;
  logic [DW-1:0]    tx_shift;
  logic [DW-1:0]    rd_hold;
  logic [AW-1:0]    addr;
  logic             hold_pend;

  logic [DW-1:0] rx_next;
  logic [AW-1:0] addr_inc;
  logic          word_done;

  assign rx_next   = {rx_shift[DW-2:0], simo_s};
  assign addr_inc  = addr + 1'b1;
  assign word_done = (bit_cnt == CNT_W'(FRAME_BITS - 1));

  assign SOMI    = tx_shift[DW-1];
  assign busy    = ~cs_s;
  assign SOMI_OE = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rd_hold   <= '0;
      addr      <= '0;
      hold_pend <= 1'b0;
      rd_addr   <= '0;
      rd_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
    end else begin
      rd_req    <= 1'b0;
      wr_en     <= 1'b0;
      // rd_data is valid the clk after rd_req; an aborted prefetch may still land here harmlessly
      hold_pend <= rd_req;
      if (hold_pend) rd_hold <= rd_data;

      if (cs_s) begin
        state    <= IDLE;
        tx_shift <= '0;
      end else if (state == IDLE) begin
        state    <= CMD;
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
      end else if (sclk_rise) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 1'b1;
        if (word_done) begin
          case (state)
            CMD: begin
              addr <= rx_next[AW-1:0];
              if (rx_next[CMD_WR_BIT]) begin
                state <= WR;
              end else begin
                state   <= RD;
                rd_addr <= rx_next[AW-1:0];
                rd_req  <= 1'b1;
              end
            end
            RD: begin
              addr    <= addr_inc;
              rd_addr <= addr_inc;
              rd_req  <= 1'b1;
            end
            WR: begin
              wr_addr <= addr;
              wr_data <= rx_next;
              wr_en   <= 1'b1;
              addr    <= addr_inc;
            end
            default: ;
          endcase
        end
      end else if (sclk_fall && state == RD) begin
        // the fall that closes a word presents the prefetched word's MSB before the next rise
        if (bit_cnt == '0) tx_shift <= rd_hold;
        else               tx_shift <= {tx_shift[DW-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_bus.sv
// Randomized and directed frames against a frame-level model of the SPI register responder.
module tb_spi_slave_bus;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SCLK = 1'b0;
  logic        CS = 1'b1;
  logic        SIMO = 1'b0;
  logic        SOMI, SOMI_OE, rd_req, wr_en, busy;
  logic [11:0] rd_addr, wr_addr;
  logic [15:0] rd_data = 16'h0000;
  logic [15:0] wr_data;

  spi_slave_bus dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .CS(CS), .SIMO(SIMO),
    .SOMI(SOMI), .SOMI_OE(SOMI_OE), .rd_addr(rd_addr), .rd_req(rd_req),
    .rd_data(rd_data), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy)
  );

  always #10 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] resp_mem [4096];
  logic [15:0] fw [8];
  logic [27:0] wr_log [$];
  logic [11:0] rd_log [$];
  logic        somi_q [$];
  logic        overlap;
  int          oe_hits;
  int          half = 4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // bus-side responder and event log
  initial begin
    overlap = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wr_en) wr_log.push_back({wr_addr, wr_data});
        if (rd_req) begin
          rd_log.push_back(rd_addr);
          rd_data = resp_mem[rd_addr];
        end
        if (rd_req && wr_en) overlap = 1'b1;
      end
    end
  end

  task automatic frame(input int nbits, input int rst_at);
    int          sent;
    int          nfull;
    int          n_wr;
    int          n_rd;
    int          nwords;
    logic [11:0] a0;
    logic [11:0] a;
    logic        is_wr;
    logic [15:0] obs_w;
    logic [15:0] exp_w;
    logic        eb;
    wr_log.delete();
    rd_log.delete();
    somi_q.delete();
    overlap = 1'b0;
    oe_hits = 0;
    sent = nbits;
    CS = 1'b0;
    wait_clk(3);
    for (int i = 0; i < nbits; i++) begin
      SIMO = fw[i/16][15-(i%16)];
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", {28'h0, SOMI, SOMI_OE, rd_req, wr_en}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_addr", {8'h0, rd_addr, wr_addr}, 32'h0);
        chk("rst_wdata", {16'h0, wr_data}, 32'h0);
        sent = i;
        break;
      end
      wait_clk(half);
      somi_q.push_back(SOMI);
      if (SOMI_OE) oe_hits++;
      SCLK = 1'b1;
      wait_clk(half);
      SCLK = 1'b0;
    end
    wait_clk(2);
    CS = 1'b1;
    if (rst_at >= 0) begin
      wait_clk(2);
      rst_n = 1'b1;
    end else begin
      wait_clk(3);
      chk("busy_end", {31'h0, busy}, 32'h0);
      chk("oe_end", {31'h0, SOMI_OE}, 32'h0);
    end
    wait_clk(3);

    // expectations from the frame rules
    nfull = sent / 16;
    a0    = fw[0][11:0];
    is_wr = fw[0][15];
    n_wr  = (nfull >= 1 && is_wr)  ? nfull - 1 : 0;
    n_rd  = (nfull >= 1 && !is_wr) ? nfull     : 0;
    chk("wr_cnt", 32'(wr_log.size()), 32'(n_wr));
    chk("rd_cnt", 32'(rd_log.size()), 32'(n_rd));
    for (int i = 0; i < n_wr && i < wr_log.size(); i++) begin
      a = a0 + 12'(i);
      chk("wr_ev", {4'h0, wr_log[i]}, {4'h0, a, fw[i+1]});
    end
    for (int i = 0; i < n_rd && i < rd_log.size(); i++) begin
      a = a0 + 12'(i);
      chk("rd_addr", {20'h0, rd_log[i]}, {20'h0, a});
    end
    nwords = (sent + 15) / 16;
    for (int w = 0; w < nwords; w++) begin
      obs_w = '0;
      exp_w = '0;
      a = a0 + 12'(w - 1);
      for (int j = w * 16; j < sent && j < w * 16 + 16; j++) begin
        eb = (w == 0 || is_wr) ? 1'b0 : resp_mem[a][15-(j%16)];
        obs_w = {obs_w[14:0], somi_q[j]};
        exp_w = {exp_w[14:0], eb};
      end
      chk("somi_word", {16'h0, obs_w}, {16'h0, exp_w});
    end
    chk("oe_frame", 32'(oe_hits), 32'(sent));
    chk("rd_wr_excl", {31'h0, overlap}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) resp_mem[i] = 16'(i) ^ 16'hFFFF;
    resp_mem[3] = 16'hA5C3;
    for (int i = 0; i < 8; i++) fw[i] = '0;

    wait_clk(2);
    chk("reset_ctl", {28'h0, SOMI, SOMI_OE, rd_req, wr_en}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_addr", {8'h0, rd_addr, wr_addr}, 32'h0);
    rst_n = 1'b1;
    wait_clk(3);

    fw[0] = 16'h8005; fw[1] = 16'h1234;
    frame(32, -1);

    fw[0] = 16'h0003;
    frame(32, -1);

    fw[0] = 16'h0010;
    frame(64, -1);

    fw[0] = 16'h8FFF; fw[1] = 16'h0001; fw[2] = 16'h0002;
    frame(48, -1);

    fw[0] = 16'h8020; fw[1] = 16'hBEEF;
    frame(25, -1);
    fw[0] = 16'h8021; fw[1] = 16'h5A5A;
    frame(32, -1);

    fw[0] = 16'h8030; fw[1] = 16'hC0DE;
    frame(32, 23);
    fw[0] = 16'h0002;
    frame(32, -1);

    for (int n = 0; n < 20; n++) begin
      int ndata;
      int part;
      for (int i = 0; i < 8; i++) fw[i] = 16'($urandom);
      ndata = $urandom_range(0, 3);
      part  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
      half  = $urandom_range(4, 6);
      frame(16 * (1 + ndata) + part, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
